// File: rtl/mask_stat_if.sv
// Video-in / frame-result bundle for mask_stat.
// The master drives the pixel stream and receives the per-frame statistics.
// The slave is the statistics block.
interface mask_stat_if #(
   parameter int unsigned H_WIDTH   = 11,
   parameter int unsigned V_WIDTH   = 11,
   parameter int unsigned CNT_WIDTH = 22
);

   logic                 i_de;
   logic                 i_vsync;
   logic                 i_mask;
   logic                 o_valid;
   logic                 o_found;
   logic [CNT_WIDTH-1:0] o_count;
   logic [H_WIDTH-1:0]   o_x_min;
   logic [H_WIDTH-1:0]   o_x_max;
   logic [V_WIDTH-1:0]   o_y_min;
   logic [V_WIDTH-1:0]   o_y_max;

   modport master (
      output i_de, i_vsync, i_mask,
      input  o_valid, o_found, o_count, o_x_min, o_x_max, o_y_min, o_y_max
   );

   modport slave (
      input  i_de, i_vsync, i_mask,
      output o_valid, o_found, o_count, o_x_min, o_x_max, o_y_min, o_y_max
   );

endinterface

// File: rtl/mask_stat.sv
// mask_stat: per-frame colour-mask statistics.
// It counts the masked pixels in each frame, reports found when the count
// reaches MIN_COUNT, and optionally tracks the bounding box of the masked pixels.
// i_mask arrives one cycle after its i_de/i_vsync. The block delays de/vsync
// by one stage so the three signals line up.
// Optional feature: define MASK_STAT_BBOX_EN to build the bounding-box logic.
// Without it, o_x_*/o_y_* are tied to 0.
module mask_stat #(
   parameter int unsigned H_WIDTH   = 11,
   parameter int unsigned V_WIDTH   = 11,
   parameter int unsigned CNT_WIDTH = 22,
   parameter int unsigned MIN_COUNT = 64
) (
   input  logic        sys_clk,
   input  logic        sys_rst_n,
   mask_stat_if.slave  bus
);

   // Compare the count against MIN_COUNT in at least 32 bits.
   // A narrow counter therefore never truncates the threshold.
   localparam int unsigned CMP_WIDTH = (CNT_WIDTH > 32) ? CNT_WIDTH : 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACC  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;

   logic                 de_d;
   logic                 vs_d;
   logic                 vs_dd;
   logic                 vs_rise;
   logic                 pix_hit;
   logic                 acc_en;
   logic                 acc_clear;
   logic                 frame_close;

   logic [CNT_WIDTH-1:0] cnt_q;
   logic [CNT_WIDTH-1:0] cnt_d;

   logic                 valid_q;
   logic                 found_q;
   logic [CNT_WIDTH-1:0] count_q;

   // One-stage delay of the sync signals, aligning them with i_mask
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_d  <= 1'b0;
         vs_d  <= 1'b0;
         vs_dd <= 1'b0;
      end else begin
         de_d  <= bus.i_de;
         vs_d  <= bus.i_vsync;
         vs_dd <= vs_d;
      end
   end

   assign vs_rise = vs_d & ~vs_dd;
   assign pix_hit = de_d & bus.i_mask;
   assign acc_en  = (state_q == ACC) & pix_hit;

   // FSM state register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state.
   // The first vsync after reset only arms accumulation.
   // Every later vsync closes a frame.
   always_comb begin
      state_d     = state_q;
      acc_clear   = 1'b0;
      frame_close = 1'b0;
      case (state_q)
         IDLE: begin
            acc_clear = 1'b1;
            if (vs_rise) begin
               state_d = ACC;
            end
         end
         ACC: begin
            if (vs_rise) begin
               state_d     = DONE;
               frame_close = 1'b1;
            end
         end
         DONE: begin
            state_d   = ACC;
            acc_clear = 1'b1;
         end
         default: begin
            state_d   = IDLE;
            acc_clear = 1'b1;
         end
      endcase
   end

   // Next value of the saturating mask-pixel count.
   // It includes a pixel that coincides with the closing vsync.
   always_comb begin
      cnt_d = cnt_q;
      if (acc_clear) begin
         cnt_d = '0;
      end else if (acc_en && (cnt_q != {CNT_WIDTH{1'b1}})) begin
         cnt_d = cnt_q + CNT_WIDTH'(1);
      end
   end

   // Mask-pixel count register
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Result registers: load on frame close, so o_valid is high during DONE.
   // Count and found hold until the next close.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         valid_q <= 1'b0;
         found_q <= 1'b0;
         count_q <= '0;
      end else begin
         valid_q <= frame_close;
         if (frame_close) begin
            count_q <= cnt_d;
            found_q <= (CMP_WIDTH'(cnt_d) >= CMP_WIDTH'(MIN_COUNT));
         end
      end
   end

   assign bus.o_valid = valid_q;
   assign bus.o_found = found_q;
   assign bus.o_count = count_q;

`ifdef MASK_STAT_BBOX_EN

   logic                 de_dd;
   logic                 de_fall;
   logic [H_WIDTH-1:0]   x_q;
   logic [V_WIDTH-1:0]   y_q;
   logic [H_WIDTH-1:0]   x_min_q;
   logic [H_WIDTH-1:0]   x_max_q;
   logic [V_WIDTH-1:0]   y_min_q;
   logic [V_WIDTH-1:0]   y_max_q;
   logic [H_WIDTH-1:0]   x_min_d;
   logic [H_WIDTH-1:0]   x_max_d;
   logic [V_WIDTH-1:0]   y_min_d;
   logic [V_WIDTH-1:0]   y_max_d;
   logic [H_WIDTH-1:0]   o_x_min_q;
   logic [H_WIDTH-1:0]   o_x_max_q;
   logic [V_WIDTH-1:0]   o_y_min_q;
   logic [V_WIDTH-1:0]   o_y_max_q;

   assign de_fall = de_dd & ~de_d;

   // Delayed de, used to detect the end of each line
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         de_dd <= 1'b0;
      end else begin
         de_dd <= de_d;
      end
   end

   // Column counter: saturating.
   // It gives the column of the pixel in the current cycle and resets after each line.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_q <= '0;
      end else if (de_fall) begin
         x_q <= '0;
      end else if (de_d && (x_q != {H_WIDTH{1'b1}})) begin
         x_q <= x_q + H_WIDTH'(1);
      end
   end

   // Row counter: saturating. It steps at each line end and resets on vsync.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         y_q <= '0;
      end else if (vs_rise) begin
         y_q <= '0;
      end else if (de_fall && (y_q != {V_WIDTH{1'b1}})) begin
         y_q <= y_q + V_WIDTH'(1);
      end
   end

   // Next running bounds of the masked pixels.
   // Minima start at all-ones and maxima start at zero.
   always_comb begin
      x_min_d = x_min_q;
      x_max_d = x_max_q;
      y_min_d = y_min_q;
      y_max_d = y_max_q;
      if (acc_clear) begin
         x_min_d = {H_WIDTH{1'b1}};
         x_max_d = '0;
         y_min_d = {V_WIDTH{1'b1}};
         y_max_d = '0;
      end else if (acc_en) begin
         if (x_q < x_min_q) x_min_d = x_q;
         if (x_q > x_max_q) x_max_d = x_q;
         if (y_q < y_min_q) y_min_d = y_q;
         if (y_q > y_max_q) y_max_d = y_q;
      end
   end

   // Running bound registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         x_min_q <= {H_WIDTH{1'b1}};
         x_max_q <= '0;
         y_min_q <= {V_WIDTH{1'b1}};
         y_max_q <= '0;
      end else begin
         x_min_q <= x_min_d;
         x_max_q <= x_max_d;
         y_min_q <= y_min_d;
         y_max_q <= y_max_d;
      end
   end

   // Bounding-box results.
   // An empty frame reports 0 rather than the initial extremes.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         o_x_min_q <= '0;
         o_x_max_q <= '0;
         o_y_min_q <= '0;
         o_y_max_q <= '0;
      end else if (frame_close) begin
         if (cnt_d == '0) begin
            o_x_min_q <= '0;
            o_x_max_q <= '0;
            o_y_min_q <= '0;
            o_y_max_q <= '0;
         end else begin
            o_x_min_q <= x_min_d;
            o_x_max_q <= x_max_d;
            o_y_min_q <= y_min_d;
            o_y_max_q <= y_max_d;
         end
      end
   end

   assign bus.o_x_min = o_x_min_q;
   assign bus.o_x_max = o_x_max_q;
   assign bus.o_y_min = o_y_min_q;
   assign bus.o_y_max = o_y_max_q;

`else

   // Bounding box not built: the box outputs read 0
   assign bus.o_x_min = '0;
   assign bus.o_x_max = '0;
   assign bus.o_y_min = '0;
   assign bus.o_y_max = '0;

`endif

endmodule

// File: tb/tb_mask_stat.sv
// Directed bench for mask_stat.
// Two instances share one pixel stream:
//   dut_a uses the default 22-bit count.
//   dut_b uses a 4-bit count, which exercises saturation.
// Both use MIN_COUNT = 4. Expected box values follow MASK_STAT_BBOX_EN.
module tb_mask_stat;

   localparam int unsigned H_W   = 11;
   localparam int unsigned V_W   = 11;
   localparam int unsigned CNT_A = 22;
   localparam int unsigned CNT_B = 4;
   localparam int unsigned MIN_C = 4;

   logic sys_clk;
   logic sys_rst_n;
   logic de;
   logic vs;
   logic mk;
   logic mask_pend;

   int   n_checks = 0;
   int   n_errors = 0;
   int   valid_a  = 0;
   int   valid_b  = 0;
   int   va_snap;
   int   vb_snap;

   mask_stat_if #(.H_WIDTH(H_W), .V_WIDTH(V_W), .CNT_WIDTH(CNT_A)) bus_a ();
   mask_stat_if #(.H_WIDTH(H_W), .V_WIDTH(V_W), .CNT_WIDTH(CNT_B)) bus_b ();

   assign bus_a.i_de    = de;
   assign bus_a.i_vsync = vs;
   assign bus_a.i_mask  = mk;
   assign bus_b.i_de    = de;
   assign bus_b.i_vsync = vs;
   assign bus_b.i_mask  = mk;

   mask_stat #(.H_WIDTH(H_W), .V_WIDTH(V_W), .CNT_WIDTH(CNT_A), .MIN_COUNT(MIN_C)) dut_a (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_a.slave)
   );

   mask_stat #(.H_WIDTH(H_W), .V_WIDTH(V_W), .CNT_WIDTH(CNT_B), .MIN_COUNT(MIN_C)) dut_b (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (bus_b.slave)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   // Count result strobes seen by each instance
   always @(negedge sys_clk) begin
      if (bus_a.o_valid === 1'b1) valid_a++;
      if (bus_b.o_valid === 1'b1) valid_b++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] bb(input int v);
`ifdef MASK_STAT_BBOX_EN
      return 32'(v);
`else
      return 32'd0 & 32'(v);
`endif
   endfunction

   // One pixel clock. The mask bit is presented one cycle after its de.
   task automatic tick(input logic d, input logic v, input logic m);
      @(negedge sys_clk);
      de        = d;
      vs        = v;
      mk        = mask_pend;
      mask_pend = m;
   endtask

   function automatic logic pix(input int mode, input int c, input int r, input int w);
      case (mode)
         1:       return (c >= 5) && (c <= 7) && (r >= 2) && (r <= 3);
         2:       return (r * w + c) < 20;
         default: return 1'b0;
      endcase
   endfunction

   task automatic rows(input int w, input int r0, input int r1, input int mode);
      for (int r = r0; r < r1; r++) begin
         tick(1'b0, 1'b0, 1'b0);
         tick(1'b0, 1'b0, 1'b0);
         for (int c = 0; c < w; c++) tick(1'b1, 1'b0, pix(mode, c, r, w));
      end
   endtask

   task automatic frame(input int w, input int h, input int mode);
      rows(w, 0, h, mode);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
   endtask

   // Vsync pulse.
   // When a result is due, o_valid must be high exactly in the second sampled cycle.
   task automatic vsync(input string tag, input logic exp_res, input logic d0, input logic m0);
      tick(d0, 1'b1, m0);
      for (int k = 1; k <= 3; k++) begin
         tick(1'b0, 1'b1, 1'b0);
         check($sformatf("%s.valid_a%0d", tag, k), 32'(bus_a.o_valid), 32'(exp_res && (k == 2)));
         check($sformatf("%s.valid_b%0d", tag, k), 32'(bus_b.o_valid), 32'(exp_res && (k == 2)));
      end
      tick(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check_out(input string tag, input int ca, input int cb, input int fa,
                            input int fb, input int x0, input int x1, input int y0, input int y1);
      check({tag, ".cnt_a"},   32'(bus_a.o_count), 32'(ca));
      check({tag, ".cnt_b"},   32'(bus_b.o_count), 32'(cb));
      check({tag, ".found_a"}, 32'(bus_a.o_found), 32'(fa));
      check({tag, ".found_b"}, 32'(bus_b.o_found), 32'(fb));
      check({tag, ".xmin_a"},  32'(bus_a.o_x_min), bb(x0));
      check({tag, ".xmax_a"},  32'(bus_a.o_x_max), bb(x1));
      check({tag, ".ymin_a"},  32'(bus_a.o_y_min), bb(y0));
      check({tag, ".ymax_a"},  32'(bus_a.o_y_max), bb(y1));
      check({tag, ".xmin_b"},  32'(bus_b.o_x_min), bb(x0));
      check({tag, ".ymax_b"},  32'(bus_b.o_y_max), bb(y1));
   endtask

   initial begin
      de        = 1'b0;
      vs        = 1'b0;
      mk        = 1'b0;
      mask_pend = 1'b0;
      sys_rst_n = 1'b0;
      repeat (3) @(negedge sys_clk);
      check("rst.valid_a", 32'(bus_a.o_valid), 32'd0);
      check_out("rst", 0, 0, 0, 0, 0, 0, 0, 0);
      sys_rst_n = 1'b1;

      // Two empty frames give one result, and that result is all zero
      vsync("v0", 1'b0, 1'b0, 1'b0);
      frame(16, 8, 0);
      vsync("v1", 1'b1, 1'b0, 1'b0);
      check_out("empty", 0, 0, 0, 0, 0, 0, 0, 0);
      check("empty.pulses_a", 32'(valid_a), 32'd1);
      check("empty.pulses_b", 32'(valid_b), 32'd1);

      // 3x2 block at x=5..7, y=2..3
      frame(16, 8, 1);
      vsync("v2", 1'b1, 1'b0, 1'b0);
      check_out("block", 6, 6, 1, 1, 5, 7, 2, 3);

      // 20 masked pixels: dut_b saturates at 15
      frame(16, 8, 2);
      vsync("v3", 1'b1, 1'b0, 1'b0);
      check_out("sat", 20, 15, 1, 1, 0, 15, 0, 1);

      // A masked pixel on the vsync edge belongs to the closing frame (x=0, y=8)
      frame(16, 8, 0);
      vsync("v4", 1'b1, 1'b1, 1'b1);
      check_out("edge", 1, 1, 0, 0, 0, 0, 8, 8);

      // The following empty frame starts from zero
      frame(16, 8, 0);
      vsync("v5", 1'b1, 1'b0, 1'b0);
      check_out("after_edge", 0, 0, 0, 0, 0, 0, 0, 0);

      frame(16, 8, 1);
      vsync("v6", 1'b1, 1'b0, 1'b0);
      check_out("block2", 6, 6, 1, 1, 5, 7, 2, 3);

      // Asynchronous reset mid-frame clears the outputs between clock edges
      rows(16, 0, 3, 1);
      #2 sys_rst_n = 1'b0;
      #1;
      check("midrst.valid_a", 32'(bus_a.o_valid), 32'd0);
      check_out("midrst", 0, 0, 0, 0, 0, 0, 0, 0);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      sys_rst_n = 1'b1;
      va_snap = valid_a;
      vb_snap = valid_b;
      rows(16, 3, 8, 1);
      tick(1'b0, 1'b0, 1'b0);
      tick(1'b0, 1'b0, 1'b0);
      vsync("r0", 1'b0, 1'b0, 1'b0);
      check_out("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);
      frame(16, 8, 2);
      check("pre_r1.cnt_a", 32'(bus_a.o_count), 32'd0);
      vsync("r1", 1'b1, 1'b0, 1'b0);
      check_out("post_rst_res", 20, 15, 1, 1, 0, 15, 0, 1);
      check("rst.pulses_a", 32'(valid_a - va_snap), 32'd1);
      check("rst.pulses_b", 32'(valid_b - vb_snap), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
